// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared constants, stage-entry type and helpers for the hazard scoreboard
package hazard_pkg;

    localparam int HZ_AW = 5;
    localparam int HZ_TW = 3;

    localparam logic [HZ_TW-1:0] TNEW_ALU = 3'd1;
    localparam logic [HZ_TW-1:0] TNEW_DM  = 3'd2;
    localparam logic [HZ_TW-1:0] TNEW_PC  = 3'd1;
    localparam logic [HZ_TW-1:0] TNEW_MD  = 3'd1;

    // Forward select 0 means the register file; k>0 names the post-decode stage
    localparam int FWD_RF = 0;
    localparam int STG_D  = 0;
    localparam int STG_E  = 1;
    localparam int STG_M  = 2;
    localparam int STG_W  = 3;

    typedef struct packed {
        logic             valid;
        logic [HZ_AW-1:0] rs;
        logic [HZ_AW-1:0] rt;
        logic [HZ_AW-1:0] dst;
        logic [HZ_TW-1:0] rdy;
        logic             md_start;
        logic             csr_wr;
        logic [HZ_TW-1:0] md_lat;
    } stage_entry_t;

    function automatic logic [HZ_TW-1:0] sat_dec(input logic [HZ_TW-1:0] v);
        return (v == '0) ? v : v - HZ_TW'(1);
    endfunction

    // $0 is hardwired zero, so it never creates a dependency
    function automatic logic is_match(input stage_entry_t e, input logic [HZ_AW-1:0] a);
        return e.valid && (e.dst == a) && (a != '0);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - decode-stage fields in, stall/forward controls out
interface hazard_scoreboard_if #(
    parameter int NSTAGES = 3,
    parameter int AW      = 5,
    parameter int TW      = 3,
    parameter int SW      = $clog2(NSTAGES + 1)
);
    logic              flush;
    logic              d_valid;
    logic [AW-1:0]     d_rs;
    logic [AW-1:0]     d_rt;
    logic              d_use_rs;
    logic              d_use_rt;
    logic [TW-1:0]     d_tuse_rs;
    logic [TW-1:0]     d_tuse_rt;
    logic [AW-1:0]     d_dst;
    logic [TW-1:0]     d_tnew;
    logic              d_md_start;
    logic [TW-1:0]     d_md_lat;
    logic              d_md_use;
    logic              d_csr_wr;
    logic              d_csr_rd;
    logic              pc_en;
    logic              regd_en;
    logic              rege_clear;
    logic [NSTAGES*SW-1:0] fwd_rs;
    logic [NSTAGES*SW-1:0] fwd_rt;
    logic              md_busy;

    modport master (
        output flush, d_valid, d_rs, d_rt, d_use_rs, d_use_rt, d_tuse_rs, d_tuse_rt,
               d_dst, d_tnew, d_md_start, d_md_lat, d_md_use, d_csr_wr, d_csr_rd,
        input  pc_en, regd_en, rege_clear, fwd_rs, fwd_rt, md_busy
    );

    modport slave (
        input  flush, d_valid, d_rs, d_rt, d_use_rs, d_use_rt, d_tuse_rs, d_tuse_rt,
               d_dst, d_tnew, d_md_start, d_md_lat, d_md_use, d_csr_wr, d_csr_rd,
        output pc_en, regd_en, rege_clear, fwd_rs, fwd_rt, md_busy
    );
endinterface

// File: rtl/hz_stage_reg.sv
// rtl/hz_stage_reg.sv - one pipeline-stage scoreboard entry with ready countdown
module hz_stage_reg
    import hazard_pkg::*;
#(
    parameter bit DEC = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_clear,
    input  stage_entry_t i_load,
    output stage_entry_t o_entry
);

    stage_entry_t r_entry;

    // Reset or clear inserts an empty entry; otherwise capture upstream, counting rdy down when shifting
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_entry <= '0;
        end else begin
            r_entry <= i_load;
            if (DEC) begin
                r_entry.rdy <= sat_dec(i_load.rdy);
            end
        end
    end

    assign o_entry = r_entry;

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - in-order pipeline hazard unit: stalls, bubbles, forward selects
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NSTAGES   = 3,
    parameter int AW        = HZ_AW,
    parameter int TW        = HZ_TW,
    parameter int CSR_DEPTH = 2,
    parameter int SW        = $clog2(NSTAGES + 1)
) (
    input  logic               clk,
    input  logic               reset,
    hazard_scoreboard_if.slave hz_bus
);

    // AW/TW must equal the package widths because the stage entry type is shared
    stage_entry_t          w_stg [1:NSTAGES];
    stage_entry_t          w_d_entry;
    logic [AW-1:0]         w_op_rs [0:NSTAGES-1];
    logic [AW-1:0]         w_op_rt [0:NSTAGES-1];
    logic [NSTAGES*SW-1:0] w_fwd_rs;
    logic [NSTAGES*SW-1:0] w_fwd_rt;
    logic                  w_rs_late;
    logic                  w_rt_late;
    logic                  w_csr_pend;
    logic                  w_data_stall;
    logic                  w_md_stall;
    logic                  w_csr_stall;
    logic                  w_stall;
    logic                  w_md_issue;
    logic                  w_md_busy;
    logic [TW-1:0]         r_md_cnt;

    assign w_d_entry.valid    = hz_bus.d_valid;
    assign w_d_entry.rs       = hz_bus.d_rs;
    assign w_d_entry.rt       = hz_bus.d_rt;
    assign w_d_entry.dst      = hz_bus.d_dst;
    assign w_d_entry.rdy      = hz_bus.d_tnew;
    assign w_d_entry.md_start = hz_bus.d_md_start;
    assign w_d_entry.csr_wr   = hz_bus.d_csr_wr;
    assign w_d_entry.md_lat   = hz_bus.d_md_lat;

    for (genvar g = 1; g <= NSTAGES; g++) begin : g_stage
        if (g == 1) begin : g_first
            hz_stage_reg #(.DEC(1'b0)) u_reg (
                .clk     (clk),
                .reset   (reset),
                .i_clear (hz_bus.flush | w_stall),
                .i_load  (w_d_entry),
                .o_entry (w_stg[g])
            );
        end else begin : g_rest
            hz_stage_reg #(.DEC(1'b1)) u_reg (
                .clk     (clk),
                .reset   (reset),
                .i_clear (hz_bus.flush),
                .i_load  (w_stg[g-1]),
                .o_entry (w_stg[g])
            );
        end
    end

    // Data interlock: only the youngest producer of each used operand decides readiness
    always_comb begin
        w_rs_late = 1'b0;
        w_rt_late = 1'b0;
        for (int k = NSTAGES; k >= 1; k--) begin
            if (is_match(w_stg[k], hz_bus.d_rs)) w_rs_late = (w_stg[k].rdy > hz_bus.d_tuse_rs);
            if (is_match(w_stg[k], hz_bus.d_rt)) w_rt_late = (w_stg[k].rdy > hz_bus.d_tuse_rt);
        end
    end

    // Pending CSR writes in the early stages block a CSR-reading instruction in D
    always_comb begin
        w_csr_pend = 1'b0;
        for (int k = 1; k <= CSR_DEPTH; k++) begin
            w_csr_pend = w_csr_pend | (w_stg[k].valid & w_stg[k].csr_wr);
        end
    end

    assign w_md_issue   = w_stg[STG_E].valid & w_stg[STG_E].md_start;
    assign w_md_busy    = (r_md_cnt != '0);
    assign w_data_stall = hz_bus.d_valid & ((hz_bus.d_use_rs & w_rs_late) | (hz_bus.d_use_rt & w_rt_late));
    assign w_md_stall   = hz_bus.d_valid & hz_bus.d_md_use & (w_md_busy | w_md_issue);
    assign w_csr_stall  = hz_bus.d_valid & hz_bus.d_csr_rd & w_csr_pend;
    assign w_stall      = ~hz_bus.flush & (w_data_stall | w_md_stall | w_csr_stall);

    // MD unit busy counter: loads when the op sits in stage 1, counts to idle; flush lets it finish
    always_ff @(posedge clk) begin
        if (reset) begin
            r_md_cnt <= '0;
        end else if (w_md_issue) begin
            r_md_cnt <= w_stg[STG_E].md_lat;
        end else if (w_md_busy) begin
            r_md_cnt <= r_md_cnt - TW'(1);
        end
    end

    // Source operands seen by each consumer stage (D first, then stage entries)
    always_comb begin
        w_op_rs[STG_D] = hz_bus.d_rs;
        w_op_rt[STG_D] = hz_bus.d_rt;
        for (int c = 1; c < NSTAGES; c++) begin
            w_op_rs[c] = w_stg[c].rs;
            w_op_rt[c] = w_stg[c].rt;
        end
    end

    // Forward from the youngest older producer only if its result is already available
    always_comb begin
        w_fwd_rs = '0;
        w_fwd_rt = '0;
        for (int c = 0; c < NSTAGES; c++) begin
            for (int k = NSTAGES; k > c; k--) begin
                if (is_match(w_stg[k], w_op_rs[c]))
                    w_fwd_rs[c*SW +: SW] = (w_stg[k].rdy == '0) ? SW'(k) : SW'(FWD_RF);
                if (is_match(w_stg[k], w_op_rt[c]))
                    w_fwd_rt[c*SW +: SW] = (w_stg[k].rdy == '0) ? SW'(k) : SW'(FWD_RF);
            end
        end
    end

    assign hz_bus.pc_en      = ~w_stall;
    assign hz_bus.regd_en    = ~w_stall;
    assign hz_bus.rege_clear = w_stall;
    assign hz_bus.fwd_rs     = w_fwd_rs;
    assign hz_bus.fwd_rt     = w_fwd_rt;
    assign hz_bus.md_busy    = w_md_busy;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - scoreboard-queue bench for hazard_scoreboard
module tb_hazard_scoreboard;
    import hazard_pkg::*;

    typedef struct packed {
        logic       rst;
        logic       fl;
        logic       v;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic [2:0] trs;
        logic [2:0] trt;
        logic [4:0] dst;
        logic [2:0] tnew;
        logic       mds;
        logic [2:0] mdl;
        logic       mdu;
        logic       cw;
        logic       cr;
        logic [15:0] exp;
    } step_t;

    logic        clk;
    logic        reset;
    logic [15:0] obs;
    logic [15:0] sb [$];
    int          n_checks;
    int          n_fail;

    hazard_scoreboard_if #(.NSTAGES(3), .AW(5), .TW(3)) hz ();

    hazard_scoreboard #(.NSTAGES(3), .AW(5), .TW(3), .CSR_DEPTH(2)) dut (
        .clk    (clk),
        .reset  (reset),
        .hz_bus (hz)
    );

    always #5 clk = ~clk;

    assign obs = {hz.pc_en, hz.regd_en, hz.rege_clear, hz.md_busy, hz.fwd_rs, hz.fwd_rt};

    function automatic logic [15:0] ex(input logic stall, input logic busy,
                                       input logic [5:0] frs, input logic [5:0] frt);
        return {~stall, ~stall, stall, busy, frs, frt};
    endfunction

    function automatic step_t ins(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                                  input logic urs, input logic urt, input logic [2:0] trs,
                                  input logic [2:0] trt, input logic [4:0] dst, input logic [2:0] tnew);
        step_t s;
        s = '0;
        s.v = v; s.rs = rs; s.rt = rt; s.urs = urs; s.urt = urt;
        s.trs = trs; s.trt = trt; s.dst = dst; s.tnew = tnew;
        return s;
    endfunction

    task automatic apply(input step_t s);
        reset         = s.rst;
        hz.flush      = s.fl;
        hz.d_valid    = s.v;
        hz.d_rs       = s.rs;
        hz.d_rt       = s.rt;
        hz.d_use_rs   = s.urs;
        hz.d_use_rt   = s.urt;
        hz.d_tuse_rs  = s.trs;
        hz.d_tuse_rt  = s.trt;
        hz.d_dst      = s.dst;
        hz.d_tnew     = s.tnew;
        hz.d_md_start = s.mds;
        hz.d_md_lat   = s.mdl;
        hz.d_md_use   = s.mdu;
        hz.d_csr_wr   = s.cw;
        hz.d_csr_rd   = s.cr;
    endtask

    task automatic test_reset();
        step_t s; step_t st[$]; logic [15:0] e;
        s = ins(0, 0, 0, 0, 0, 0, 0, 0, 0); s.exp = ex(0, 0, 0, 0); st.push_back(s);
        s = ins(1, 3, 0, 1, 0, 0, 0, 0, 0); s.exp = ex(0, 0, 0, 0); st.push_back(s);
        foreach (st[i]) begin
            sb.push_back(st[i].exp); apply(st[i]);
            @(negedge clk); e = sb.pop_front(); n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL reset step %0d: got %b want %b", i, obs, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_use();
        step_t s; step_t st[$]; logic [15:0] e;
        s = ins(1, 29, 0, 1, 0, 0, 0, 8, TNEW_DM); s.exp = ex(0, 0, 0, 0); st.push_back(s);
        s = ins(1, 8, 0, 1, 1, 0, 0, 0, 0);        s.exp = ex(1, 0, 0, 0); st.push_back(s); st.push_back(s);
        s.exp = ex(0, 0, 6'b000011, 0); st.push_back(s);
        s = ins(0, 0, 0, 0, 0, 0, 0, 0, 0); s.exp = ex(0, 0, 0, 0);
        repeat (3) st.push_back(s);
        foreach (st[i]) begin
            sb.push_back(st[i].exp); apply(st[i]);
            @(negedge clk); e = sb.pop_front(); n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL load_use step %0d: got %b want %b", i, obs, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_alu_forward();
        step_t s; step_t st[$]; logic [15:0] e;
        s = ins(1, 1, 2, 1, 1, 1, 1, 3, TNEW_ALU); s.exp = ex(0, 0, 0, 0); st.push_back(s);
        s = ins(1, 3, 3, 1, 1, 1, 1, 4, TNEW_ALU); s.exp = ex(0, 0, 0, 0); st.push_back(s);
        s = ins(0, 0, 0, 0, 0, 0, 0, 0, 0); s.exp = ex(0, 0, 6'b001000, 6'b001000); st.push_back(s);
        s.exp = ex(0, 0, 6'b110000, 6'b110000); st.push_back(s);
        s.exp = ex(0, 0, 0, 0); repeat (3) st.push_back(s);
        foreach (st[i]) begin
            sb.push_back(st[i].exp); apply(st[i]);
            @(negedge clk); e = sb.pop_front(); n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL alu_forward step %0d: got %b want %b", i, obs, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_youngest();
        step_t s; step_t st[$]; logic [15:0] e;
        s = ins(1, 0, 0, 0, 0, 0, 0, 5, TNEW_ALU); s.exp = ex(0, 0, 0, 0); st.push_back(s);
        s = ins(1, 0, 0, 0, 0, 0, 0, 5, TNEW_DM);  s.exp = ex(0, 0, 0, 0); st.push_back(s);
        s = ins(1, 5, 0, 1, 0, 0, 0, 0, 0);        s.exp = ex(1, 0, 0, 0); st.push_back(s); st.push_back(s);
        s.exp = ex(0, 0, 6'b000011, 0); st.push_back(s);
        s = ins(0, 0, 0, 0, 0, 0, 0, 0, 0); s.exp = ex(0, 0, 0, 0); repeat (3) st.push_back(s);
        foreach (st[i]) begin
            sb.push_back(st[i].exp); apply(st[i]);
            @(negedge clk); e = sb.pop_front(); n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL youngest step %0d: got %b want %b", i, obs, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_zero_reg();
        step_t s; step_t st[$]; logic [15:0] e;
        s = ins(1, 0, 0, 0, 0, 0, 0, 0, TNEW_DM); s.exp = ex(0, 0, 0, 0); st.push_back(s);
        s = ins(1, 0, 0, 1, 1, 0, 0, 0, 0);       s.exp = ex(0, 0, 0, 0); st.push_back(s); st.push_back(s);
        s = ins(0, 0, 0, 0, 0, 0, 0, 0, 0); s.exp = ex(0, 0, 0, 0); repeat (3) st.push_back(s);
        foreach (st[i]) begin
            sb.push_back(st[i].exp); apply(st[i]);
            @(negedge clk); e = sb.pop_front(); n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL zero_reg step %0d: got %b want %b", i, obs, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_csr_flush();
        step_t s; step_t mt; step_t er; step_t id; step_t st[$]; logic [15:0] e;
        mt = ins(1, 0, 0, 0, 0, 0, 0, 0, 0); mt.cw = 1'b1; mt.exp = ex(0, 0, 0, 0);
        er = ins(1, 0, 0, 0, 0, 0, 0, 0, 0); er.cr = 1'b1;
        id = ins(0, 0, 0, 0, 0, 0, 0, 0, 0); id.exp = ex(0, 0, 0, 0);
        st.push_back(mt);
        s = er; s.exp = ex(1, 0, 0, 0); st.push_back(s); st.push_back(s);
        s = er; s.exp = ex(0, 0, 0, 0); st.push_back(s);
        repeat (3) st.push_back(id);
        st.push_back(mt);
        s = er; s.fl = 1'b1; s.exp = ex(0, 0, 0, 0); st.push_back(s);
        s = er; s.exp = ex(0, 0, 0, 0); st.push_back(s);
        repeat (3) st.push_back(id);
        foreach (st[i]) begin
            sb.push_back(st[i].exp); apply(st[i]);
            @(negedge clk); e = sb.pop_front(); n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL csr_flush step %0d: got %b want %b", i, obs, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_md();
        step_t s; step_t st[$]; logic [15:0] e;
        s = ins(1, 0, 0, 0, 0, 0, 0, 0, 0); s.mds = 1'b1; s.mdl = 3'd5; s.mdu = 1'b1;
        s.exp = ex(0, 0, 0, 0); st.push_back(s);
        for (int i = 1; i <= 7; i++) begin
            s = ins(1, 0, 0, 0, 0, 0, 0, 2, TNEW_MD); s.mdu = 1'b1; s.fl = (i == 3);
            s.exp = ex((i <= 6) && (i != 3), (i >= 2) && (i <= 6), 0, 0);
            st.push_back(s);
        end
        s = ins(0, 0, 0, 0, 0, 0, 0, 0, 0); s.exp = ex(0, 0, 0, 0); repeat (3) st.push_back(s);
        foreach (st[i]) begin
            sb.push_back(st[i].exp); apply(st[i]);
            @(negedge clk); e = sb.pop_front(); n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL md step %0d: got %b want %b", i, obs, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        step_t s; step_t st[$]; logic [15:0] e;
        s = ins(1, 0, 0, 0, 0, 0, 0, 0, 0); s.mds = 1'b1; s.mdl = 3'd5;
        s.exp = ex(0, 0, 0, 0); st.push_back(s);
        s = ins(1, 0, 0, 0, 0, 0, 0, 6, TNEW_ALU); s.exp = ex(0, 0, 0, 0); st.push_back(s);
        s = ins(1, 0, 0, 0, 0, 0, 0, 8, TNEW_ALU); s.exp = ex(0, 1, 0, 0); st.push_back(s);
        s = ins(1, 6, 0, 1, 0, 1, 0, 7, TNEW_ALU); s.exp = ex(0, 1, 6'b000010, 0); st.push_back(s);
        s = ins(1, 7, 6, 1, 1, 1, 1, 9, TNEW_ALU); s.rst = 1'b1;
        s.exp = ex(0, 1, 6'b001100, 6'b000011); st.push_back(s);
        s = ins(1, 6, 7, 1, 1, 0, 0, 0, 0); s.exp = ex(0, 0, 0, 0); st.push_back(s);
        s = ins(0, 0, 0, 0, 0, 0, 0, 0, 0); s.exp = ex(0, 0, 0, 0); repeat (2) st.push_back(s);
        foreach (st[i]) begin
            sb.push_back(st[i].exp); apply(st[i]);
            @(negedge clk); e = sb.pop_front(); n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL reset_mid step %0d: got %b want %b", i, obs, e); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        clk      = 1'b0;
        n_checks = 0;
        n_fail   = 0;
        apply(ins(0, 0, 0, 0, 0, 0, 0, 0, 0));
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_load_use();
        test_alu_forward();
        test_youngest();
        test_zero_reg();
        test_csr_flush();
        test_md();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
